nibble_run_controller: RTL and testbench
========================================

// Module: nibble_run_controller
// PURPOSE
//  Program loader and run/step/halt sequencer for the NibbleBuddy core.
//  Streams a host-supplied program into the 32x8 instruction memory and holds the core in reset meanwhile.
//  Then gates the core's clock enable for free-run, single-step and PC breakpoints.
//  Sits between the host/debug port and the processor's reset, clock-enable and program_counter pins.
// PARAMETERS
//  PC_WIDTH     5   width of program counter and instruction-memory address
//  INSTR_WIDTH  8   instruction word width
//  PROG_DEPTH   32  words per load; must be <= 2**PC_WIDTH
//  RESET_HOLD   2   cycles cpu_reset stays high after a load completes (>=1)
// PORTS
//  clk         in   1            system clock, rising edge
//  reset       in   1            asynchronous, active-low reset
//  load_start  in   1            pulse: begin program load at address 0
//  run_cmd     in   1            pulse: free-run the core
//  step_cmd    in   1            pulse: execute exactly one core cycle
//  halt_cmd    in   1            pulse: stop the core
//  host_valid  in   1            host_data holds a valid instruction word
//  host_ready  out  1            controller accepts host_data this cycle
//  host_data   in   INSTR_WIDTH  instruction word from host
//  bp_enable   in   1            breakpoint enable
//  bp_addr     in   PC_WIDTH     breakpoint PC
//  cpu_pc      in   PC_WIDTH     processor program_counter
//  cpu_reset   out  1            active-high reset to processor
//  cpu_clk_en  out  1            processor clock enable
//  imem_we     out  1            instruction-memory write strobe
//  imem_addr   out  PC_WIDTH     instruction-memory write address
//  imem_wdata  out  INSTR_WIDTH  instruction-memory write data (= host_data)
//  load_done   out  1            one-cycle pulse when the last word is written
//  bp_hit      out  1            one-cycle pulse when the breakpoint stops the core
//  state       out  3            IDLE=0 LOAD=1 RSTCPU=2 HALT=3 RUN=4 STEP=5
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE, load counter=0, cpu_reset=1.
//   - cpu_clk_en, host_ready, imem_we, load_done and bp_hit all 0.
//   - Reset mid-load aborts the load: no load_done; memory keeps the partial program.
//  IDLE:
//   - cpu_reset=1, cpu_clk_en=0.
//   - load_start -> LOAD. run_cmd and step_cmd are ignored.
//  LOAD:
//   - cpu_reset=1, host_ready=1.
//   - imem_we = host_valid&host_ready (combinational); imem_addr=counter; counter++ on each write.
//   - Write of word PROG_DEPTH-1: load_done=1 next cycle, counter->0, enter RSTCPU.
//   - host_ready=0 from that cycle on.
//   - All commands are ignored; host gaps (host_valid=0) are allowed indefinitely.
//  RSTCPU:
//   - cpu_reset=1 for exactly RESET_HOLD cycles, then HALT.
//  HALT:
//   - cpu_reset=0, cpu_clk_en=0.
//   - Command priority: halt_cmd > load_start > step_cmd > run_cmd.
//   - halt_cmd: stay in HALT. load_start: LOAD, cpu_reset=1 next cycle.
//   - step_cmd: STEP. run_cmd: RUN.
//  RUN:
//   - cpu_clk_en=1 from the cycle after run_cmd.
//   - halt_cmd: HALT, cpu_clk_en=0 from the next cycle.
//   - Breakpoint: bp_enable & (cpu_pc==bp_addr) while armed.
//     cpu_clk_en=0 combinationally in that same cycle, so the instruction at bp_addr does not execute.
//     bp_hit=1 that cycle; state -> HALT.
//   - armed=0 in the first RUN cycle after HALT, 1 afterwards, so resuming from a breakpoint makes progress.
//   - load_start, step_cmd and run_cmd are ignored in RUN.
//  STEP:
//   - cpu_clk_en=1 for exactly one cycle, then HALT.
//   - The breakpoint is not checked; all commands are ignored.
//  Outputs:
//   - Registered, except host_ready/imem_* (decoded from state) and the breakpoint gating of cpu_clk_en/bp_hit.
//   - Counter wraps modulo 2**PC_WIDTH; it never exceeds PROG_DEPTH-1.
// TESTING
//  1 Hold reset=0 -> state=0, cpu_reset=1, all other outputs 0; release -> still IDLE; run_cmd ignored.
//  2 load_start, then 32 words 0x00..0x1F with host_valid gaps.
//    -> exactly 32 imem_we, addr 0..31 with matching data.
//    -> load_done for one cycle; cpu_reset high 2 more cycles; state=3.
//  3 run_cmd, then halt_cmd 10 cycles later -> cpu_clk_en high exactly 10 cycles; state back to 3.
//  4 Core model pc++ per enabled cycle, bp_enable=1, bp_addr=5, run_cmd.
//    -> cpu_clk_en=0 while pc=5; one bp_hit pulse.
//    -> a second run_cmd steps past 5 with no new bp_hit until wrap.
//  5 step_cmd -> cpu_clk_en high exactly 1 cycle; run_cmd+step_cmd+halt_cmd together in HALT -> stays HALT, clk_en 0.
//  6 Assert reset after 10 words loaded -> IDLE, no load_done; a new load_start writes from addr 0.

Source files
------------

// File: rtl/nibble_run_controller.sv
// -----------------------------------------------------------------------------
// nibble_run_controller
//
// Program loader and run/step/halt sequencer for the NibbleBuddy core.
// A host streams a program into the instruction memory while the core is
// held in reset. Once the load completes, the controller keeps the core in
// reset for a few more cycles and then parks it in HALT. From HALT the host
// can free-run the core, single-step it, or stop it at a PC breakpoint.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   load_start  pulse: begin program load at address 0
//   run_cmd     pulse: free-run the core
//   step_cmd    pulse: execute exactly one core cycle
//   halt_cmd    pulse: stop the core
//   host_valid  host_data holds a valid instruction word
//   host_ready  controller accepts host_data this cycle
//   host_data   instruction word from the host
//   bp_enable   breakpoint enable
//   bp_addr     breakpoint PC
//   cpu_pc      processor program counter
//   cpu_reset   active-high reset to the processor
//   cpu_clk_en  processor clock enable
//   imem_we     instruction-memory write strobe
//   imem_addr   instruction-memory write address
//   imem_wdata  instruction-memory write data (passes host_data through)
//   load_done   one-cycle pulse after the last word is written
//   bp_hit      one-cycle pulse when the breakpoint stops the core
//   state       IDLE=0 LOAD=1 RSTCPU=2 HALT=3 RUN=4 STEP=5
// -----------------------------------------------------------------------------
module nibble_run_controller #(
    parameter int PC_WIDTH    = 5,
    parameter int INSTR_WIDTH = 8,
    parameter int PROG_DEPTH  = 32,
    parameter int RESET_HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic                   run_cmd,
    input  logic                   step_cmd,
    input  logic                   halt_cmd,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [INSTR_WIDTH-1:0] host_data,
    input  logic                   bp_enable,
    input  logic [PC_WIDTH-1:0]    bp_addr,
    input  logic [PC_WIDTH-1:0]    cpu_pc,
    output logic                   cpu_reset,
    output logic                   cpu_clk_en,
    output logic                   imem_we,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   load_done,
    output logic                   bp_hit,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RSTCPU = 3'd2,
        ST_HALT   = 3'd3,
        ST_RUN    = 3'd4,
        ST_STEP   = 3'd5
    } state_t;

    // The hold counter only has to count 0 .. RESET_HOLD-1.
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    localparam logic [PC_WIDTH-1:0] CNT_LAST  = PC_WIDTH'(PROG_DEPTH - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    state_t              state_q,     state_d;
    logic [PC_WIDTH-1:0] cnt_q,       cnt_d;
    logic [HOLD_W-1:0]   hold_q,      hold_d;
    logic                armed_q,     armed_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                clk_en_q,    clk_en_d;
    logic                load_done_q, load_done_d;

    logic                load_active_s;
    logic                write_s;
    logic                bp_match_s;

    // Host handshake and memory write port, decoded straight from state.
    always_comb begin
        load_active_s = (state_q == ST_LOAD);
        write_s       = load_active_s & host_valid;
    end

    // Breakpoint detection: only while free-running and armed. Disarming in
    // the first RUN cycle lets a resume from the breakpoint PC execute it.
    always_comb begin
        if ((state_q == ST_RUN) && armed_q && bp_enable && (cpu_pc == bp_addr)) begin
            bp_match_s = 1'b1;
        end else begin
            bp_match_s = 1'b0;
        end
    end

    // Next-state, load counter and reset-hold counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        load_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = {PC_WIDTH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                if (write_s) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d       = {PC_WIDTH{1'b0}};
                        hold_d      = {HOLD_W{1'b0}};
                        load_done_d = 1'b1;
                        state_d     = ST_RSTCPU;
                    end else begin
                        cnt_d = cnt_q + PC_WIDTH'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_RSTCPU: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = {HOLD_W{1'b0}};
                    state_d = ST_HALT;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            ST_HALT: begin
                // halt_cmd > load_start > step_cmd > run_cmd
                if (halt_cmd) begin
                    state_d = ST_HALT;
                end else if (load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = {PC_WIDTH{1'b0}};
                end else if (step_cmd) begin
                    state_d = ST_STEP;
                end else if (run_cmd) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end

            ST_RUN: begin
                if (halt_cmd || bp_match_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_STEP: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = {PC_WIDTH{1'b0}};
                hold_d  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Registered core controls follow the state being entered, so they line
    // up with the state register one cycle after the command.
    always_comb begin
        case (state_d)
            ST_IDLE, ST_LOAD, ST_RSTCPU: begin
                cpu_reset_d = 1'b1;
                clk_en_d    = 1'b0;
            end
            ST_RUN, ST_STEP: begin
                cpu_reset_d = 1'b0;
                clk_en_d    = 1'b1;
            end
            ST_HALT: begin
                cpu_reset_d = 1'b0;
                clk_en_d    = 1'b0;
            end
            default: begin
                cpu_reset_d = 1'b1;
                clk_en_d    = 1'b0;
            end
        endcase

        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            armed_d = 1'b1;
        end else begin
            armed_d = 1'b0;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {PC_WIDTH{1'b0}};
            hold_q      <= {HOLD_W{1'b0}};
            armed_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            clk_en_q    <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            armed_q     <= armed_d;
            cpu_reset_q <= cpu_reset_d;
            clk_en_q    <= clk_en_d;
            load_done_q <= load_done_d;
        end
    end

    // A breakpoint match kills the clock enable in the same cycle, so the
    // instruction at bp_addr never executes.
    assign cpu_clk_en = clk_en_q & ~bp_match_s;
    assign bp_hit     = bp_match_s;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign host_ready = load_active_s;
    assign imem_we    = write_s;
    assign imem_addr  = cnt_q;
    assign imem_wdata = host_data;
    assign state      = state_q;

endmodule

// File: tb/tb_nibble_run_controller.sv
// -----------------------------------------------------------------------------
// tb_nibble_run_controller
//
// Self-checking bench for nibble_run_controller. Instruction-memory writes are
// checked against a scoreboard queue filled as the host offers words. A small
// core model advances its PC on every enabled, non-reset cycle.
// -----------------------------------------------------------------------------
module tb_nibble_run_controller;

    logic       clk;
    logic       reset;
    logic       load_start;
    logic       run_cmd;
    logic       step_cmd;
    logic       halt_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] host_data;
    logic       bp_enable;
    logic [4:0] bp_addr;
    logic [4:0] core_pc;
    logic       cpu_reset;
    logic       cpu_clk_en;
    logic       imem_we;
    logic [4:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       load_done;
    logic       bp_hit;
    logic [2:0] state;

    nibble_run_controller #(
        .PC_WIDTH    (5),
        .INSTR_WIDTH (8),
        .PROG_DEPTH  (32),
        .RESET_HOLD  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .run_cmd    (run_cmd),
        .step_cmd   (step_cmd),
        .halt_cmd   (halt_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_data  (host_data),
        .bp_enable  (bp_enable),
        .bp_addr    (bp_addr),
        .cpu_pc     (core_pc),
        .cpu_reset  (cpu_reset),
        .cpu_clk_en (cpu_clk_en),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .load_done  (load_done),
        .bp_hit     (bp_hit),
        .state      (state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected writes: {addr[4:0], data[7:0]}
    logic [12:0] sb_q[$];

    int we_cnt     = 0;
    int ld_cnt     = 0;
    int bp_cnt     = 0;
    int en_cnt     = 0;
    int en_bp_cnt  = 0;

    int snap_we, snap_ld, snap_bp, snap_en, snap_enbp;
    int exp_en;
    int hit;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Core model: PC cleared in reset, advances on each enabled cycle.
    always @(posedge clk) begin
        if (cpu_reset) begin
            core_pc <= 5'd0;
        end else if (cpu_clk_en) begin
            core_pc <= core_pc + 5'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard writes and count event pulses mid-cycle.
    always @(negedge clk) begin
        logic [12:0] e;
        if (imem_we) begin
            we_cnt <= we_cnt + 1;
            if (sb_q.size() == 0) begin
                chk("we_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("imem_addr",  32'(imem_addr),  32'(e[12:8]));
                chk("imem_wdata", 32'(imem_wdata), 32'(e[7:0]));
            end
        end
        if (load_done)  ld_cnt <= ld_cnt + 1;
        if (bp_hit)     bp_cnt <= bp_cnt + 1;
        if (cpu_clk_en) en_cnt <= en_cnt + 1;
        if (cpu_clk_en && bp_enable && (core_pc == bp_addr)) en_bp_cnt <= en_bp_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic l, input logic r, input logic s, input logic h);
        load_start = l;
        run_cmd    = r;
        step_cmd   = s;
        halt_cmd   = h;
        tick();
        load_start = 1'b0;
        run_cmd    = 1'b0;
        step_cmd   = 1'b0;
        halt_cmd   = 1'b0;
    endtask

    // Offer n words with random gaps; each accepted word is queued.
    task automatic load_words(input int n, input logic [7:0] base);
        int acc;
        int cyc;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 400) begin
            host_valid = ($urandom_range(0, 3) != 0);
            host_data  = 8'(int'(base) + acc);
            if (host_valid && host_ready) begin
                sb_q.push_back({5'(acc), host_data});
                acc++;
            end
            tick();
            cyc++;
        end
        host_valid = 1'b0;
        chk("load_accept", 32'(acc), 32'(n));
    endtask

    // Run until bp_hit is seen (bounded).
    task automatic wait_bp(output int seen);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (bp_hit) begin
                seen = 1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        reset      = 1'b0;
        load_start = 1'b0;
        run_cmd    = 1'b0;
        step_cmd   = 1'b0;
        halt_cmd   = 1'b0;
        host_valid = 1'b0;
        host_data  = 8'd0;
        bp_enable  = 1'b0;
        bp_addr    = 5'd0;

        // 1: reset state, commands ignored in IDLE
        tick(); tick(); tick();
        chk("rst_state",      32'(state),      32'd0);
        chk("rst_cpu_reset",  32'(cpu_reset),  32'd1);
        chk("rst_clk_en",     32'(cpu_clk_en), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_imem_we",    32'(imem_we),    32'd0);
        chk("rst_load_done",  32'(load_done),  32'd0);
        chk("rst_bp_hit",     32'(bp_hit),     32'd0);
        reset = 1'b1;
        tick();
        chk("idle_after_rst", 32'(state), 32'd0);
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("idle_ignore_cmd", 32'(state),      32'd0);
        chk("idle_clk_en",     32'(cpu_clk_en), 32'd0);
        chk("idle_cpu_reset",  32'(cpu_reset),  32'd1);

        // 2: full 32-word load with gaps
        snap_we = we_cnt;
        snap_ld = ld_cnt;
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("load_state", 32'(state),      32'd1);
        chk("load_ready", 32'(host_ready), 32'd1);
        load_words(32, 8'h00);
        chk("ld_pulse",      32'(load_done),  32'd1);
        chk("ld_state_rc",   32'(state),      32'd2);
        chk("ld_cpu_reset0", 32'(cpu_reset),  32'd1);
        chk("ld_ready_off",  32'(host_ready), 32'd0);
        tick();
        chk("ld_pulse_end",  32'(load_done),  32'd0);
        chk("ld_cpu_reset1", 32'(cpu_reset),  32'd1);
        chk("ld_state_rc1",  32'(state),      32'd2);
        tick();
        chk("ld_state_halt", 32'(state),      32'd3);
        chk("ld_cpu_rel",    32'(cpu_reset),  32'd0);
        chk("ld_clk_en",     32'(cpu_clk_en), 32'd0);
        tick();
        chk("ld_we_count",   32'(we_cnt - snap_we), 32'd32);
        chk("ld_done_count", 32'(ld_cnt - snap_ld), 32'd1);
        chk("ld_sb_empty",   32'(sb_q.size()),      32'd0);

        // 3: run then halt 10 cycles later
        snap_en = en_cnt;
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        chk("run_state", 32'(state), 32'd4);
        for (int k = 0; k < 9; k++) tick();
        cmd(1'b0, 1'b0, 1'b0, 1'b1);
        chk("halt_clk_off", 32'(cpu_clk_en), 32'd0);
        tick(); tick();
        chk("run_en_count", 32'(en_cnt - snap_en), 32'd10);
        chk("halt_state",   32'(state),            32'd3);
        chk("halt_pc",      32'(core_pc),          32'd10);

        // 4: breakpoint at 5, then resume past it
        bp_enable = 1'b1;
        bp_addr   = 5'd5;
        exp_en = (5 - int'(core_pc)) & 31;
        if (exp_en == 0) exp_en = 32;
        snap_en   = en_cnt;
        snap_bp   = bp_cnt;
        snap_enbp = en_bp_cnt;
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        wait_bp(hit);
        chk("bp1_seen",     32'(hit),        32'd1);
        chk("bp1_gate",     32'(cpu_clk_en), 32'd0);
        chk("bp1_pc",       32'(core_pc),    32'd5);
        tick(); tick();
        chk("bp1_state",    32'(state),                32'd3);
        chk("bp1_hits",     32'(bp_cnt - snap_bp),     32'd1);
        chk("bp1_en_count", 32'(en_cnt - snap_en),     32'(exp_en));
        chk("bp1_en_at_bp", 32'(en_bp_cnt - snap_enbp), 32'd0);

        snap_en   = en_cnt;
        snap_bp   = bp_cnt;
        snap_enbp = en_bp_cnt;
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp2_past",     32'(core_pc), 32'd6);
        wait_bp(hit);
        chk("bp2_seen",     32'(hit),        32'd1);
        chk("bp2_gate",     32'(cpu_clk_en), 32'd0);
        tick(); tick();
        chk("bp2_state",    32'(state),                 32'd3);
        chk("bp2_hits",     32'(bp_cnt - snap_bp),      32'd1);
        chk("bp2_en_count", 32'(en_cnt - snap_en),      32'd32);
        chk("bp2_en_at_bp", 32'(en_bp_cnt - snap_enbp), 32'd1);
        bp_enable = 1'b0;

        // 5: single step, then simultaneous commands in HALT
        snap_en = en_cnt;
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        chk("step_state", 32'(state),      32'd5);
        chk("step_clk",   32'(cpu_clk_en), 32'd1);
        tick(); tick(); tick();
        chk("step_count", 32'(en_cnt - snap_en), 32'd1);
        chk("step_halt",  32'(state),            32'd3);
        snap_en = en_cnt;
        cmd(1'b0, 1'b1, 1'b1, 1'b1);
        chk("prio_state", 32'(state),      32'd3);
        chk("prio_clk",   32'(cpu_clk_en), 32'd0);
        tick(); tick(); tick();
        chk("prio_count", 32'(en_cnt - snap_en), 32'd0);

        // 6: reset in the middle of a load, then reload from address 0
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reload_state", 32'(state),     32'd1);
        chk("reload_rst",   32'(cpu_reset), 32'd1);
        snap_ld = ld_cnt;
        load_words(10, 8'h40);
        reset = 1'b0;
        tick();
        chk("abort_state", 32'(state),      32'd0);
        chk("abort_rst",   32'(cpu_reset),  32'd1);
        chk("abort_ready", 32'(host_ready), 32'd0);
        reset = 1'b1;
        tick(); tick();
        chk("abort_no_done", 32'(ld_cnt - snap_ld), 32'd0);
        chk("abort_sb",      32'(sb_q.size()),      32'd0);
        snap_we = we_cnt;
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        load_words(32, 8'hA0);
        tick(); tick(); tick();
        chk("rl_done_count", 32'(ld_cnt - snap_ld), 32'd1);
        chk("rl_we_count",   32'(we_cnt - snap_we), 32'd32);
        chk("rl_state",      32'(state),            32'd3);
        chk("rl_sb_empty",   32'(sb_q.size()),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
